pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of stall_count.
REQ-002 SHALL have parameter: FLUSH_W, 16, width of flush_count.
REQ-003 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: hazard_stall  input  1  load-use stall from forwarding unit.
REQ-006 SHALL have port: br_redirect  input  1  EX-stage taken branch/jump, PC target valid.
REQ-007 SHALL have port: imem_resp  input  1  instruction fetch completed this cycle.
REQ-008 SHALL have port: dmem_req  input  1  MEM-stage instruction is a load or store.
REQ-009 SHALL have port: dmem_resp  input  1  data access completed this cycle.
REQ-010 SHALL have ports: pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  output  1 each  pipeline register enables.
REQ-011 SHALL have ports: if_id_flush, id_ex_flush, ex_mem_bubble  output  1 each  load a NOP/cleared control word instead of upstream data.
REQ-012 SHALL have ports: stall_count  output  CNT_W  and  flush_count  output  FLUSH_W  performance counters.

Function
REQ-013 SHALL hold a state register with states RUN and DISCARD; enables and flushes are combinational from state and inputs.
REQ-014 SHALL define mem_stall = dmem_req & ~dmem_resp, fetch_stall = ~imem_resp.
REQ-015 Priority 1, mem_stall: all five enables 0, all flush/bubble 0, state unchanged; hazard_stall, br_redirect and fetch_stall are ignored that cycle.
REQ-016 Priority 2, hazard_stall: pc_load, if_id_load, id_ex_load = 0; ex_mem_load = 1 with ex_mem_bubble = 1; mem_wb_load = 1; br_redirect ignored.
REQ-017 Priority 3, br_redirect: all enables 1, if_id_flush = 1, id_ex_flush = 1; flush_count increments.
REQ-018 Redirect accepted while fetch_stall in RUN SHALL still assert pc_load = 1 and SHALL move state to DISCARD.
REQ-019 Priority 4, fetch_stall (no redirect): pc_load = 0, if_id_load = 1 with if_id_flush = 1, id_ex_load, ex_mem_load, mem_wb_load = 1.
REQ-020 Otherwise (RUN, no event): all enables 1, all flush/bubble 0.
REQ-021 In DISCARD with imem_resp = 1 and no higher-priority event: pc_load = 0, if_id_load = 1, if_id_flush = 1, downstream enables 1; next state RUN (wrong-path word dropped).
REQ-022 In DISCARD with imem_resp = 0: behave as REQ-019, stay in DISCARD.
REQ-023 In DISCARD, a new br_redirect SHALL apply REQ-017 and stay in DISCARD (or go to RUN if imem_resp = 1 same cycle, response discarded).
REQ-024 stall_count SHALL increment every cycle with pc_load = 0 outside reset; both counters SHALL saturate at all-ones, no wrap.
REQ-025 Counter updates and state transitions occur on rising clk only; outputs have zero-cycle latency from inputs.

Reset
REQ-026 On rst assertion, state SHALL immediately become RUN and both counters 0, independent of clk.
REQ-027 While rst = 1: all enables 0, if_id_flush, id_ex_flush, ex_mem_bubble = 1, counters held at 0.
REQ-028 First rising clk after rst deassertion SHALL follow REQ-015..REQ-022 from RUN; reset mid-DISCARD SHALL abandon the discard.

Verification
REQ-029 Load-use: hazard_stall = 1 one cycle, other inputs idle-good -> pc/if_id/id_ex_load = 0, ex_mem_bubble = 1, mem_wb_load = 1; stall_count 0 -> 1.
REQ-030 Data-miss: dmem_req = 1, dmem_resp = 0 for 3 cycles, hazard_stall = 1 and br_redirect = 1 concurrent -> all enables 0, no flush, stall_count = 3, flush_count = 0.
REQ-031 Redirect during fetch miss: imem_resp = 0, br_redirect = 1 -> pc_load = 1, both flushes 1, flush_count = 1, state DISCARD; next imem_resp = 1 -> pc_load = 0, if_id_flush = 1, state RUN.
REQ-032 Saturation: preload via 2^CNT_W-1 stall cycles (CNT_W overridden to 4) -> stall_count reaches 15, holds at 15 after further stalls.
REQ-033 Async reset: assert rst between clk edges while in DISCARD with counters non-zero -> counters 0 and enables 0 before next edge; after release, imem_resp = 1 -> normal RUN advance, no discard.

Source files
------------

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline register enables, flush/bubble control and stall/flush counters
module pipeline_control #(
  parameter int CNT_W   = 32,
  parameter int FLUSH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_stall,
  input  logic               br_redirect,
  input  logic               imem_resp,
  input  logic               dmem_req,
  input  logic               dmem_resp,
  output logic               pc_load,
  output logic               if_id_load,
  output logic               id_ex_load,
  output logic               ex_mem_load,
  output logic               mem_wb_load,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               ex_mem_bubble,
  output logic [CNT_W-1:0]   stall_count,
  output logic [FLUSH_W-1:0] flush_count
);

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [FLUSH_W-1:0] flush_count_q, flush_count_d;

  logic mem_stall;
  logic fetch_stall;
  logic redirect_taken;

  assign mem_stall   = dmem_req & ~dmem_resp;
  assign fetch_stall = ~imem_resp;

  always_comb begin
    state_d        = state_q;
    redirect_taken = 1'b0;
    pc_load        = 1'b1;
    if_id_load     = 1'b1;
    id_ex_load     = 1'b1;
    ex_mem_load    = 1'b1;
    mem_wb_load    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_bubble  = 1'b0;

    if (rst) begin
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_load   = 1'b0;
      mem_wb_load   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
    end else if (hazard_stall) begin
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (br_redirect) begin
      redirect_taken = 1'b1;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      // A redirect during an outstanding fetch must drop the late wrong-path word.
      if (state_q == RUN) begin
        state_d = fetch_stall ? DISCARD : RUN;
      end else begin
        state_d = imem_resp ? RUN : DISCARD;
      end
    end else if (state_q == DISCARD) begin
      pc_load     = 1'b0;
      if_id_flush = 1'b1;
      if (imem_resp) begin
        state_d = RUN;
      end
    end else if (fetch_stall) begin
      pc_load     = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!pc_load && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (redirect_taken && (flush_count_q != {FLUSH_W{1'b1}})) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - vector table plus scoreboard bench for pipeline_control
module tb_pipeline_control;

  localparam logic [7:0] ALL_RUN = 8'b11111_000;
  localparam logic [7:0] MEM_ST  = 8'b00000_000;
  localparam logic [7:0] HAZ     = 8'b00011_001;
  localparam logic [7:0] REDIR   = 8'b11111_110;
  localparam logic [7:0] FETCH   = 8'b01111_100;
  localparam logic [7:0] RST_OUT = 8'b00000_111;

  // input bit order: {hazard_stall, br_redirect, imem_resp, dmem_req, dmem_resp}
  localparam logic [4:0] I_IDLE   = 5'b00100;
  localparam logic [4:0] I_MHIT   = 5'b00111;
  localparam logic [4:0] I_HAZ    = 5'b10100;
  localparam logic [4:0] I_HAZBR  = 5'b11100;
  localparam logic [4:0] I_MMISS  = 5'b11110;
  localparam logic [4:0] I_MMISS0 = 5'b00010;
  localparam logic [4:0] I_FMISS  = 5'b00000;
  localparam logic [4:0] I_BR     = 5'b01100;
  localparam logic [4:0] I_BRF    = 5'b01000;
  localparam logic [4:0] I_FMHIT  = 5'b00011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_stall = 1'b0, br_redirect = 1'b0, imem_resp = 1'b1, dmem_req = 1'b0, dmem_resp = 1'b0;

  logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic if_id_flush, id_ex_flush, ex_mem_bubble;
  logic [31:0] stall_count;
  logic [15:0] flush_count;

  logic pc_load4, if_id_load4, id_ex_load4, ex_mem_load4, mem_wb_load4;
  logic if_id_flush4, id_ex_flush4, ex_mem_bubble4;
  logic [3:0] stall_count4;
  logic [3:0] flush_count4;

  pipeline_control dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .br_redirect(br_redirect),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_control #(.CNT_W(4), .FLUSH_W(4)) dut4 (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .br_redirect(br_redirect),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(pc_load4), .if_id_load(if_id_load4), .id_ex_load(id_ex_load4),
    .ex_mem_load(ex_mem_load4), .mem_wb_load(mem_wb_load4), .if_id_flush(if_id_flush4),
    .id_ex_flush(id_ex_flush4), .ex_mem_bubble(ex_mem_bubble4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] in;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] outs;
    int         stall;
    int         flush;
  } sb_t;

  vec_t tbl[21];
  sb_t  sb_q[$];
  int   stall_exp = 0;
  int   flush_exp = 0;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive at posedge+1, compare at the following negedge, return at next posedge+1.
  task automatic step(input string name, input logic [4:0] in, input logic [7:0] exp);
    sb_t e;
    {hazard_stall, br_redirect, imem_resp, dmem_req, dmem_resp} = in;
    sb_q.push_back('{exp, stall_exp, flush_exp});
    @(negedge clk);
    e = sb_q.pop_front();
    check({name, "_outs"}, {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                           if_id_flush, id_ex_flush, ex_mem_bubble}, e.outs);
    check({name, "_outs4"}, {pc_load4, if_id_load4, id_ex_load4, ex_mem_load4, mem_wb_load4,
                            if_id_flush4, id_ex_flush4, ex_mem_bubble4}, e.outs);
    check({name, "_stall"}, stall_count, e.stall);
    check({name, "_flush"}, flush_count, e.flush);
    check({name, "_stall4"}, stall_count4, sat15(e.stall));
    check({name, "_flush4"}, flush_count4, sat15(e.flush));
    if (!exp[7]) stall_exp++;
    if (exp == REDIR) flush_exp++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    check({name, "_rst_outs"}, {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                               if_id_flush, id_ex_flush, ex_mem_bubble}, RST_OUT);
    check({name, "_rst_stall"}, stall_count, 0);
    check({name, "_rst_flush"}, flush_count, 0);
    check({name, "_rst_stall4"}, stall_count4, 0);
    @(posedge clk);
    #1;
    check({name, "_rst_hold"}, stall_count, 0);
    rst = 1'b0;
    stall_exp = 0;
    flush_exp = 0;
  endtask

  initial begin
    tbl[0]  = '{I_IDLE,   ALL_RUN};
    tbl[1]  = '{I_MHIT,   ALL_RUN};
    tbl[2]  = '{I_HAZ,    HAZ};
    tbl[3]  = '{I_HAZBR,  HAZ};
    tbl[4]  = '{I_MMISS,  MEM_ST};
    tbl[5]  = '{I_MMISS0, MEM_ST};
    tbl[6]  = '{I_FMISS,  FETCH};
    tbl[7]  = '{I_BR,     REDIR};
    tbl[8]  = '{I_IDLE,   ALL_RUN};
    tbl[9]  = '{I_BRF,    REDIR};
    tbl[10] = '{I_FMISS,  FETCH};
    tbl[11] = '{I_HAZ,    HAZ};
    tbl[12] = '{5'b00110, MEM_ST};
    tbl[13] = '{I_BRF,    REDIR};
    tbl[14] = '{I_IDLE,   FETCH};
    tbl[15] = '{I_IDLE,   ALL_RUN};
    tbl[16] = '{I_BRF,    REDIR};
    tbl[17] = '{I_BR,     REDIR};
    tbl[18] = '{I_IDLE,   ALL_RUN};
    tbl[19] = '{I_FMHIT,  FETCH};
    tbl[20] = '{I_IDLE,   ALL_RUN};

    #2;
    do_reset("init");
    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
    end

    do_reset("loaduse");
    step("lu_idle", I_IDLE, ALL_RUN);
    step("lu_haz", I_HAZ, HAZ);
    step("lu_after", I_IDLE, ALL_RUN);
    check("lu_stall_is_1", stall_count, 1);

    do_reset("dmiss");
    for (int i = 0; i < 3; i++) step("dm_miss", I_MMISS, MEM_ST);
    check("dm_stall_is_3", stall_count, 3);
    check("dm_flush_is_0", flush_count, 0);

    do_reset("redir");
    step("rd_br_fmiss", I_BRF, REDIR);
    check("rd_flush_is_1", flush_count, 1);
    step("rd_drop", I_IDLE, FETCH);
    step("rd_run", I_IDLE, ALL_RUN);

    do_reset("sat");
    for (int i = 0; i < 15; i++) step("sat_fill", I_FMISS, FETCH);
    check("sat_at_15", stall_count4, 15);
    for (int i = 0; i < 5; i++) step("sat_more", I_FMISS, FETCH);
    check("sat_hold_15", stall_count4, 15);
    check("sat_wide_20", stall_count, 20);

    do_reset("pre_async");
    step("as_fmiss", I_FMISS, FETCH);
    step("as_br_fmiss", I_BRF, REDIR);
    check("as_flush_nz", flush_count, 1);
    {hazard_stall, br_redirect, imem_resp, dmem_req, dmem_resp} = I_FMISS;
    #2;
    do_reset("async");
    step("as_run", I_IDLE, ALL_RUN);
    step("as_run2", I_IDLE, ALL_RUN);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
